// File: rtl/versatile_io_pkg.sv
// versatile_io_pkg: shared definitions for the versatile IO hub.
//   - FSM state encoding
//   - internal register offsets (word index adr[3:2])
//   - STATUS register bit positions
//   - byte-lane replicate / collapse helpers used by 8-bit channels
package versatile_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] REG_PEND   = 2'd0;  // W1C
  localparam logic [1:0] REG_MASK   = 2'd1;  // RW
  localparam logic [1:0] REG_STATUS = 2'd2;  // RO
  localparam logic [1:0] REG_RSVD   = 2'd3;  // reads 0

  localparam int STATUS_TMO_BIT = 31;  // a channel timeout has been seen
  localparam int STATUS_CH_LSB  = 0;   // [2:0] channel that timed out
  localparam int STATUS_CH_W    = 3;

  // Copy one byte onto all four lanes.
  function automatic logic [31:0] byte_replicate(input logic [7:0] b);
    return {4{b}};
  endfunction

  // OR together the byte lanes enabled by sel.
  function automatic logic [7:0] byte_collapse(input logic [31:0] d,
                                               input logic [3:0]  sel);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r = r | d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/versatile_io_irq.sv
// versatile_io_irq: interrupt pending / mask registers and the hub irq line.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ch_irq_i     : per-channel interrupt requests (level, sampled every cycle)
//   pend_w1c_i   : write strobe for IRQ_PEND (write-1-to-clear)
//   mask_we_i    : write strobe for IRQ_MASK
//   wdata_i      : write data (channel bits only)
//   pend_o/mask_o: current register contents
//   irq_o        : registered |(pend & mask)
module versatile_io_irq
  import versatile_io_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ch_irq_i,
  input  logic           pend_w1c_i,
  input  logic           mask_we_i,
  input  logic [NCH-1:0] wdata_i,
  output logic [NCH-1:0] pend_o,
  output logic [NCH-1:0] mask_o,
  output logic           irq_o
);
  logic [NCH-1:0] pend_q, pend_d, mask_q, mask_d;
  logic           irq_q, irq_d;

  always_comb begin
    pend_d = pend_q;
    if (pend_w1c_i) pend_d = pend_q & ~wdata_i;
    // A request in the same cycle as the clear keeps the bit set.
    pend_d = pend_d | ch_irq_i;
    mask_d = mask_we_i ? wdata_i : mask_q;
    irq_d  = |(pend_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/versatile_io_hub.sv
// versatile_io_hub: Wishbone slave that forwards accesses to NCH peripheral
// channels, plus a small internal register block (IRQ_PEND, IRQ_MASK, STATUS).
// Address decode: hit when adr[31:MAP_LO] matches BASE; channel index is
// adr[CH_LO+2:CH_LO]; index NCH selects internal registers, above is unmapped.
// Ports:
//   wbs_*    : Wishbone slave side (clock wbs_clk, sync active-high wbs_rst)
//   ch_*     : shared channel master bus, one ch_cyc_o bit per channel;
//              ch_dat_i packs channel i at [32i+31:32i]
//   ch_irq_i : channel interrupt requests; irq_o is the combined interrupt
// Optional feature: define VERSATILE_IO_TIMEOUT_EN to abort channel accesses
// that are not acked within TIMEOUT cycles with a bus error.
module versatile_io_hub
  import versatile_io_pkg::*;
#(
  parameter int             NCH     = 2,
  parameter logic [31:0]    BASE    = 32'h9000_0000,
  parameter int             MAP_LO  = 8,
  parameter int             CH_LO   = 5,
  parameter logic [NCH-1:0] BYTE_CH = '1,
  parameter int             TIMEOUT = 255
) (
  input  logic              wbs_clk,
  input  logic              wbs_rst,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic              wbs_we_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              wbs_stall_o,
  output logic [NCH-1:0]    ch_cyc_o,
  output logic              ch_stb_o,
  output logic              ch_we_o,
  output logic [31:0]       ch_adr_o,
  output logic [31:0]       ch_dat_o,
  output logic [3:0]        ch_sel_o,
  input  logic [NCH*32-1:0] ch_dat_i,
  input  logic [NCH-1:0]    ch_ack_i,
  input  logic [NCH-1:0]    ch_irq_i,
  output logic              irq_o
);
  state_e         state_q, state_d;
  logic [NCH-1:0] cyc_q, cyc_d;
  logic           stb_q, stb_d, we_q, we_d, byte_q, byte_d, ack_q, ack_d;
  logic [31:0]    adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]     sel_q, sel_d;

  logic           hit, is_chan, is_int, ack_hit, pend_w1c, mask_we;
  logic [2:0]     idx;
  logic [NCH-1:0] idx_oh, pend, mask;
  logic [31:0]    ch_rdat, reg_rdat, status;

`ifdef VERSATILE_IO_TIMEOUT_EN
  logic           err_q, err_d;
  logic [15:0]    tmo_q, tmo_d;
  logic [2:0]     idx_q, idx_d;
  logic [31:0]    status_q, status_d;
  assign status = status_q;
`else
  assign status = '0;
`endif

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:MAP_LO] == BASE[31:MAP_LO]);
  assign idx     = wbs_adr_i[CH_LO+2:CH_LO];
  assign is_chan = 32'(idx) < 32'(NCH);
  assign is_int  = 32'(idx) == 32'(NCH);
  assign idx_oh  = NCH'(1) << idx;  // all zero when idx >= NCH

  // cyc_q is one-hot on the active channel, so it doubles as the mux select.
  assign ack_hit = |(ch_ack_i & cyc_q);
  always_comb begin
    ch_rdat = '0;
    for (int i = 0; i < NCH; i++)
      if (cyc_q[i]) ch_rdat = ch_dat_i[32*i +: 32];
  end

  always_comb begin
    case (wbs_adr_i[3:2])
      REG_PEND:   reg_rdat = 32'(pend);
      REG_MASK:   reg_rdat = 32'(mask);
      REG_STATUS: reg_rdat = status;
      default:    reg_rdat = '0;
    endcase
  end

  // Internal register writes take effect the cycle the request is accepted.
  assign pend_w1c = (state_q == ST_IDLE) & hit & is_int & wbs_we_i & (wbs_adr_i[3:2] == REG_PEND);
  assign mask_we  = (state_q == ST_IDLE) & hit & is_int & wbs_we_i & (wbs_adr_i[3:2] == REG_MASK);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    byte_d  = byte_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    rdat_d  = '0;
`ifdef VERSATILE_IO_TIMEOUT_EN
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    status_d = status_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (is_chan) begin
            state_d = ST_FWD;
            cyc_d   = idx_oh;
            stb_d   = 1'b1;
            we_d    = wbs_we_i;
            adr_d   = wbs_adr_i;
            byte_d  = |(idx_oh & BYTE_CH);
            if (byte_d) begin
              wdat_d = byte_replicate(byte_collapse(wbs_dat_i, wbs_sel_i));
              sel_d  = 4'b0001;
            end else begin
              wdat_d = wbs_dat_i;
              sel_d  = wbs_sel_i;
            end
`ifdef VERSATILE_IO_TIMEOUT_EN
            tmo_d = 16'(TIMEOUT);
            idx_d = idx;
`endif
          end else begin
            // Internal and unmapped accesses answer directly; unmapped reads 0.
            state_d = ST_RESP;
            ack_d   = 1'b1;
            if (is_int && !wbs_we_i) rdat_d = reg_rdat;
          end
        end
      end
      ST_FWD: begin
        if (!wbs_cyc_i) begin
          // Master abandoned the cycle: drop it silently.
          state_d = ST_IDLE;
          cyc_d   = '0;
          stb_d   = 1'b0;
        end else if (ack_hit) begin
          state_d = ST_RESP;
          cyc_d   = '0;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          if (!we_q) rdat_d = byte_q ? byte_replicate(ch_rdat[7:0]) : ch_rdat;
        end
`ifdef VERSATILE_IO_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d  = ST_RESP;
          cyc_d    = '0;
          stb_d    = 1'b0;
          err_d    = 1'b1;
          status_d = '0;
          status_d[STATUS_TMO_BIT] = 1'b1;
          status_d[STATUS_CH_LSB +: STATUS_CH_W] = idx_q;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;  // RESP lasts exactly one cycle
    endcase
  end

  always_ff @(posedge wbs_clk) begin
    if (wbs_rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef VERSATILE_IO_TIMEOUT_EN
      err_q    <= 1'b0;
      tmo_q    <= '0;
      idx_q    <= '0;
      status_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
`ifdef VERSATILE_IO_TIMEOUT_EN
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      status_q <= status_d;
`endif
    end
  end

  versatile_io_irq #(.NCH(NCH)) u_irq (
    .clk       (wbs_clk),
    .rst       (wbs_rst),
    .ch_irq_i  (ch_irq_i),
    .pend_w1c_i(pend_w1c),
    .mask_we_i (mask_we),
    .wdata_i   (wbs_dat_i[NCH-1:0]),
    .pend_o    (pend),
    .mask_o    (mask),
    .irq_o     (irq_o)
  );

  assign wbs_dat_o   = rdat_q;
  assign wbs_ack_o   = ack_q;
`ifdef VERSATILE_IO_TIMEOUT_EN
  assign wbs_err_o   = err_q;
`else
  assign wbs_err_o   = 1'b0;
`endif
  assign wbs_stall_o = (state_q != ST_IDLE);
  assign ch_cyc_o    = cyc_q;
  assign ch_stb_o    = stb_q;
  assign ch_we_o     = we_q;
  assign ch_adr_o    = adr_q;
  assign ch_dat_o    = wdat_q;
  assign ch_sel_o    = sel_q;

endmodule

// File: tb/tb_versatile_io_hub.sv
// Bench for versatile_io_hub: NCH=2, channel 0 word-wide, channel 1 byte-wide,
// TIMEOUT=4. A responder models the channels, a table of accesses drives the
// main paths, and hand-written sequences cover irq, abort, reset and timeout.
module tb_versatile_io_hub;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       wbs_dat_i, wbs_adr_i;
  logic [3:0]        wbs_sel_i;
  logic              wbs_we_i, wbs_stb_i, wbs_cyc_i;
  logic [31:0]       wbs_dat_o;
  logic              wbs_ack_o, wbs_err_o, wbs_stall_o;
  logic [NCH-1:0]    ch_cyc_o;
  logic              ch_stb_o, ch_we_o;
  logic [31:0]       ch_adr_o, ch_dat_o;
  logic [3:0]        ch_sel_o;
  logic [NCH*32-1:0] ch_dat_i;
  logic [NCH-1:0]    ch_ack_i, ch_irq_i;
  logic              irq_o;

  versatile_io_hub #(
    .NCH(NCH), .BASE(32'h9000_0000), .MAP_LO(8), .CH_LO(5),
    .BYTE_CH(2'b10), .TIMEOUT(4)
  ) dut (
    .wbs_clk(clk), .wbs_rst(rst),
    .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_stall_o(wbs_stall_o),
    .ch_cyc_o(ch_cyc_o), .ch_stb_o(ch_stb_o), .ch_we_o(ch_we_o),
    .ch_adr_o(ch_adr_o), .ch_dat_o(ch_dat_o), .ch_sel_o(ch_sel_o),
    .ch_dat_i(ch_dat_i), .ch_ack_i(ch_ack_i), .ch_irq_i(ch_irq_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdat;
    int          lat;     // cycles from request sample to response
    bit          chk_ch;
    logic [1:0]  ch_cyc;
    logic [31:0] ch_dat;
    logic [3:0]  ch_sel;
  } vec_t;

  typedef struct { logic err; logic [31:0] dat; } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[13];
  vec_t v;
  int   checks = 0, failures = 0;
  int   dly[NCH];  // cycles channel waits before acking
  int   cnt[NCH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t cv(logic [31:0] adr, logic we, logic [31:0] dat, logic [3:0] sel,
                              logic [31:0] rdat, int lat, logic [1:0] cyc,
                              logic [31:0] chd, logic [3:0] chs);
    vec_t r;
    r = '{adr, we, dat, sel, 1'b0, rdat, lat, 1'b1, cyc, chd, chs};
    return r;
  endfunction

  function automatic vec_t iv(logic [31:0] adr, logic we, logic [31:0] dat, logic [31:0] rdat);
    vec_t r;
    r = '{adr, we, dat, 4'hF, 1'b0, rdat, 1, 1'b0, 2'b00, 32'h0, 4'h0};
    return r;
  endfunction

  // Channel responder: acks once the channel has been selected for dly+1 cycles.
  initial begin
    ch_ack_i = '0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        ch_ack_i[i] = 1'b0;
        if (ch_cyc_o[i] && ch_stb_o) begin
          cnt[i]++;
          if (cnt[i] == dly[i] + 1) ch_ack_i[i] = 1'b1;
        end else cnt[i] = 0;
      end
    end
  end

  // Response monitor: every ack/err must match the oldest expected response.
  initial forever begin
    @(negedge clk);
    if (wbs_ack_o || wbs_err_o) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp actual ack=%0b err=%0b required none", wbs_ack_o, wbs_err_o);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_ack", 32'(wbs_ack_o), 32'(!mon_e.err));
        chk("resp_err", 32'(wbs_err_o), 32'(mon_e.err));
        chk("resp_dat", wbs_dat_o, mon_e.dat);
      end
    end else if (!rst) chk("dat_zero_no_ack", wbs_dat_o, 32'h0);
  end

  task automatic xfer(input vec_t t, input int id);
    int  n;
    bit  seen;
    sb_t e;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wbs_adr_i = t.adr; wbs_we_i = t.we; wbs_dat_i = t.dat; wbs_sel_i = t.sel;
    e.err = t.err; e.dat = t.rdat;
    sb.push_back(e);
    n = 0; seen = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      if (t.chk_ch && !seen && ch_stb_o) begin
        seen = 1'b1;
        chk($sformatf("v%0d_ch_rise", id), 32'(n), 32'd1);
        chk($sformatf("v%0d_ch_cyc", id), 32'(ch_cyc_o), 32'(t.ch_cyc));
        chk($sformatf("v%0d_ch_adr", id), ch_adr_o, t.adr);
        chk($sformatf("v%0d_ch_we", id), 32'(ch_we_o), 32'(t.we));
        chk($sformatf("v%0d_ch_dat", id), ch_dat_o, t.ch_dat);
        chk($sformatf("v%0d_ch_sel", id), 32'(ch_sel_o), 32'(t.ch_sel));
      end
      if (wbs_ack_o || wbs_err_o) break;
      if (n >= 40) begin
        checks++; failures++;
        $display("FAIL v%0d_response actual=none required=response", id);
        sb.delete();
        break;
      end
    end
    chk($sformatf("v%0d_latency", id), 32'(n), 32'(t.lat));
    if (t.chk_ch) chk($sformatf("v%0d_ch_seen", id), 32'(seen), 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    ch_irq_i = '0;
    ch_dat_i = {32'h00C3_B2A5, 32'h1234_5678};
    dly[0] = 3; dly[1] = 1;

    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'({ch_cyc_o, ch_stb_o, ch_we_o, wbs_ack_o, wbs_err_o, wbs_stall_o, irq_o}), 32'h0);
    chk("reset_dat", wbs_dat_o, 32'h0);
    chk("reset_ch_adr", ch_adr_o, 32'h0);
    rst = 1'b0;

    tbl[0]  = cv(32'h9000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 5, 2'b01, 32'hDEAD_BEEF, 4'hF);
    tbl[1]  = cv(32'h9000_0008, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 5, 2'b01, 32'h0, 4'hF);
    tbl[2]  = cv(32'h9000_0020, 1'b0, 32'h0, 4'hF, 32'hA5A5_A5A5, 3, 2'b10, 32'h0, 4'h1);
    tbl[3]  = cv(32'h9000_0024, 1'b1, 32'h1122_3344, 4'b0110, 32'h0, 3, 2'b10, 32'h3333_3333, 4'h1);
    tbl[4]  = cv(32'h9000_0020, 1'b1, 32'h1122_3344, 4'b1001, 32'h0, 3, 2'b10, 32'h5555_5555, 4'h1);
    tbl[5]  = iv(32'h9000_0044, 1'b1, 32'h2, 32'h0);          // MASK = 2
    tbl[6]  = iv(32'h9000_0044, 1'b0, 32'h0, 32'h2);
    tbl[7]  = iv(32'h9000_004C, 1'b0, 32'h0, 32'h0);          // reserved
    tbl[8]  = iv(32'h9000_0048, 1'b0, 32'h0, 32'h0);          // STATUS clean
    tbl[9]  = iv(32'h9000_0060, 1'b0, 32'h0, 32'h0);          // idx NCH+1
    tbl[10] = iv(32'h9000_0060, 1'b1, 32'hFFFF_FFFF, 32'h0);
    tbl[11] = iv(32'h9000_00E0, 1'b0, 32'h0, 32'h0);          // idx 7
    tbl[12] = iv(32'h9000_0040, 1'b0, 32'h0, 32'h0);          // PEND clean
    for (int i = 0; i < 13; i++) xfer(tbl[i], i);

    // Address outside the hub window: no response, no forwarding.
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'hA000_0000; wbs_we_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("miss_idle", 32'({wbs_stall_o, ch_cyc_o}), 32'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

    // Interrupt pulse on channel 1 with MASK=2.
    @(negedge clk); ch_irq_i = 2'b10;
    @(negedge clk); ch_irq_i = 2'b00;
    chk("irq_not_yet", 32'(irq_o), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq_o), 32'h1);
    xfer(iv(32'h9000_0040, 1'b0, 32'h0, 32'h2), 20);
    ch_irq_i = 2'b10;                                      // set beats W1C
    xfer(iv(32'h9000_0040, 1'b1, 32'h2, 32'h0), 21);
    xfer(iv(32'h9000_0040, 1'b0, 32'h0, 32'h2), 22);
    ch_irq_i = 2'b00;
    xfer(iv(32'h9000_0040, 1'b1, 32'h2, 32'h0), 23);
    xfer(iv(32'h9000_0040, 1'b0, 32'h0, 32'h0), 24);
    repeat (2) @(negedge clk);
    chk("irq_cleared", 32'(irq_o), 32'h0);

    // Master drops cyc while the channel is stalling.
    dly[0] = 1000;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h9000_0000; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    @(negedge clk);
    chk("abort_fwd_cyc", 32'(ch_cyc_o), 32'h1);
    chk("abort_fwd_stall", 32'(wbs_stall_o), 32'h1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({ch_cyc_o, ch_stb_o, wbs_stall_o}), 32'h0);
    repeat (3) @(negedge clk);
    dly[0] = 3;
    xfer(cv(32'h9000_0000, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 5, 2'b01, 32'h0, 4'hF), 30);

`ifdef VERSATILE_IO_TIMEOUT_EN
    dly[0] = 1000;
    v = cv(32'h9000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 6, 2'b01, 32'h0, 4'hF);
    v.err = 1'b1;
    xfer(v, 40);
    xfer(iv(32'h9000_0048, 1'b0, 32'h0, 32'h8000_0000), 41);
    dly[0] = 3;
`endif

    // Reset in the middle of a forwarded write with irq_o asserted.
    @(negedge clk); ch_irq_i = 2'b10;
    @(negedge clk); ch_irq_i = 2'b00;
    dly[0] = 1000;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h9000_0000; wbs_we_i = 1'b1;
    wbs_dat_i = 32'hCAFE_F00D; wbs_sel_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_state", 32'({ch_cyc_o, ch_we_o, irq_o}), 32'b0111);
    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    chk("rst_ctl", 32'({ch_cyc_o, ch_stb_o, ch_we_o, wbs_ack_o, wbs_err_o, wbs_stall_o, irq_o}), 32'h0);
    chk("rst_ch_adr", ch_adr_o, 32'h0);
    chk("rst_ch_dat", ch_dat_o, 32'h0);
    chk("rst_ch_sel", 32'(ch_sel_o), 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    rst = 1'b0;
    dly[0] = 3;
    xfer(iv(32'h9000_0044, 1'b0, 32'h0, 32'h0), 50);
    xfer(iv(32'h9000_0040, 1'b0, 32'h0, 32'h0), 51);
    xfer(iv(32'h9000_0048, 1'b0, 32'h0, 32'h0), 52);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/versatile_io_hub.md
VERSATILE_IO_HUB -- requirements
Module: versatile_io_hub

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of peripheral channels (1..7).
REQ-002 SHALL have parameter BASE, default 32'h9000_0000, meaning hub base address.
REQ-003 SHALL have parameter MAP_LO, default 8, meaning lowest address bit compared against BASE.
REQ-004 SHALL have parameter CH_LO, default 5, meaning lowest bit of the 3-bit channel index field adr[CH_LO+2:CH_LO].
REQ-005 SHALL have parameter BYTE_CH, default all ones (NCH bits), meaning bit i set marks channel i as 8-bit.
REQ-006 SHALL have parameter TIMEOUT, default 255, meaning cycles without channel ack before bus error (1..65535).
REQ-007 SHALL have ports: wbs_clk in 1 clock; wbs_rst in 1 reset; wbs_dat_i in 32; wbs_adr_i in 32; wbs_sel_i in 4; wbs_we_i, wbs_stb_i, wbs_cyc_i in 1 each; wbs_dat_o out 32; wbs_ack_o out 1; wbs_err_o out 1; wbs_stall_o out 1.
REQ-008 SHALL have channel ports: ch_cyc_o out NCH; ch_stb_o, ch_we_o out 1; ch_adr_o out 32; ch_dat_o out 32; ch_sel_o out 4; ch_dat_i in NCH*32 (channel i at [32i+31:32i]); ch_ack_i in NCH; ch_irq_i in NCH; irq_o out 1.
REQ-009 SHALL use one clock, wbs_clk; reset wbs_rst is synchronous, active-high.

Function
REQ-010 SHALL decode hit = cyc&stb&(adr[31:MAP_LO]==BASE[31:MAP_LO]); idx = adr[CH_LO+2:CH_LO].
REQ-011 SHALL implement states IDLE, FWD, RESP.
REQ-012 IDLE: on hit with idx<NCH, SHALL latch adr/dat/sel/we, go FWD; on idx==NCH (internal regs) or idx>NCH (unmapped), SHALL go RESP directly.
REQ-013 FWD: ch_cyc_o[idx], ch_stb_o high with latched fields; other ch_cyc_o bits low.
REQ-014 FWD: on ch_ack_i[idx], SHALL capture channel data, go RESP; acks from other channels SHALL be ignored.
REQ-015 FWD: if wbs_cyc_i drops, SHALL return to IDLE, no ack, no err, no register update.
REQ-016 RESP: wbs_ack_o (or wbs_err_o) high exactly one cycle, wbs_dat_o valid, then IDLE.
REQ-017 Latency: request sampled cycle N, ch_cyc_o high N+1; channel ack cycle M gives wbs_ack_o at M+1; internal/unmapped ack at N+1.
REQ-018 wbs_stall_o SHALL be high when state != IDLE.
REQ-019 Byte channel write: ch_dat_o = 4 copies of OR of lanes enabled by sel; ch_sel_o = 4'b0001. Word channel: data, sel passed unchanged.
REQ-020 Byte channel read: wbs_dat_o = 4 copies of ch_dat_i[7:0]; word channel: unchanged.
REQ-021 wbs_dat_o SHALL be 0 whenever wbs_ack_o low; unmapped reads return 0, writes discarded.
REQ-022 Internal regs at adr[3:2]: 0 IRQ_PEND (W1C), 1 IRQ_MASK (RW), 2 STATUS (RO: bit31 timeout seen, [2:0] timed-out channel), 3 reads 0; only bits [NCH-1:0] implemented in PEND/MASK.
REQ-023 IRQ_PEND[i] SHALL set each cycle ch_irq_i[i] is high; set SHALL win over simultaneous W1C.
REQ-024 irq_o SHALL be registered |(IRQ_PEND & IRQ_MASK), one cycle after pend/mask change.

Reset
REQ-025 On wbs_rst: state IDLE; all outputs 0; IRQ_PEND, IRQ_MASK, STATUS, timeout counter 0; any FWD transaction dropped, no ack.

Configuration
REQ-026 Macro VERSATILE_IO_TIMEOUT_EN defined: counter loads TIMEOUT on FWD entry, decrements each FWD cycle; at 0 without ack, SHALL go RESP with wbs_err_o=1, wbs_ack_o=0, data 0, STATUS updated; ack on the expiry cycle SHALL win.
REQ-027 Macro undefined: no counter, FWD waits indefinitely, wbs_err_o tied 0, STATUS reads 0.

Structure
REQ-028 Package versatile_io_pkg SHALL hold state encodings, internal register offsets, STATUS bit positions, and byte-lane replicate/collapse functions.
REQ-029 Sub-module versatile_io_irq (pend/mask/irq_o) is natural; decoder, FSM, timeout stay in hub.

Verification
REQ-030 Word write ch0 (BYTE_CH=0), ack after 3 cycles -> ch_cyc_o=01 one cycle after request, wbs_ack_o 4 cycles after ch_cyc_o rise.
REQ-031 Byte read ch1, ch_dat_i[39:32]=8'hA5 -> wbs_dat_o=32'hA5A5A5A5 with ack, 0 otherwise.
REQ-032 ch_irq_i=2'b10 pulse, MASK=2'b10 -> PEND=2, irq_o=1; write PEND=2 with irq held -> PEND stays 2.
REQ-033 TIMEOUT_EN, TIMEOUT=4, ch0 never acks -> wbs_err_o one cycle, STATUS=32'h8000_0000.
REQ-034 Drop wbs_cyc_i during FWD -> IDLE, ch_cyc_o=0, no ack/err; next access completes normally.
REQ-035 Read idx=NCH+1 -> ack at N+1, data 0; wbs_rst mid-FWD -> all outputs 0 next cycle.
